// File: rtl/rtc_mode_sequencer_if.sv
// Button and mode/strobe bundle between the RTC mode sequencer and its surroundings.
// The master side is the sequencer itself; the slave side is the button/RTC-bus-master side.
interface rtc_mode_sequencer_if;
   logic       btn_program_i;
   logic       btn_next_i;
   logic       btn_exit_i;
   logic [2:0] enables_o;
   logic [3:0] cambio_o;
   logic       graba_o;
   logic       pulsoprogramo_o;
   logic       busy_o;

   modport master (
      input  btn_program_i,
      input  btn_next_i,
      input  btn_exit_i,
      output enables_o,
      output cambio_o,
      output graba_o,
      output pulsoprogramo_o,
      output busy_o
   );

   modport slave (
      output btn_program_i,
      output btn_next_i,
      output btn_exit_i,
      input  enables_o,
      input  cambio_o,
      input  graba_o,
      input  pulsoprogramo_o,
      input  busy_o
   );
endinterface

// File: rtl/rtc_mode_sequencer.sv
// Mode sequencer for the RTC bus master: init pass, periodic reads, and button-driven
// edit/commit of a single field. All outputs are registered alongside the state.
module rtc_mode_sequencer #(
   parameter int unsigned INIT_CYCLES  = 1000,
   parameter int unsigned READ_PERIOD  = 1000000,
   parameter int unsigned READ_CYCLES  = 2000,
   parameter int unsigned WRITE_CYCLES = 500,
   parameter int unsigned CNT_W        = 21
) (
   input  logic                  clk_i,
   input  logic                  reset_i,
   rtc_mode_sequencer_if.master  bus
);

   typedef enum logic [2:0] {
      S_INIT,
      S_IDLE,
      S_READ,
      S_EDIT,
      S_COMMIT
   } state_t;

   localparam logic [CNT_W-1:0] INIT_LAST   = CNT_W'(INIT_CYCLES - 1);
   localparam logic [CNT_W-1:0] PERIOD_LAST = CNT_W'(READ_PERIOD - 1);
   localparam logic [CNT_W-1:0] READ_LAST   = CNT_W'(READ_CYCLES - 1);
   localparam logic [CNT_W-1:0] WRITE_LAST  = CNT_W'(WRITE_CYCLES - 1);
   localparam logic [CNT_W-1:0] CNT_ONE     = CNT_W'(1);

   localparam logic [2:0] EN_INIT  = 3'b100;
   localparam logic [2:0] EN_READ  = 3'b010;
   localparam logic [2:0] EN_WRITE = 3'b001;
   localparam logic [2:0] EN_IDLE  = 3'b000;

   // Button bit order in the vectors below: [0] program, [1] next, [2] exit.
   logic [2:0] r_btn_s1;
   logic [2:0] r_btn_s2;
   logic [2:0] r_btn_s3;
   logic [2:0] w_btn_ev;
   logic       w_ev_prog;
   logic       w_ev_next;
   logic       w_ev_exit;

   state_t           r_state;
   logic [CNT_W-1:0] r_cnt;
   logic [2:0]       r_enables;
   logic [3:0]       r_cambio;
   logic             r_graba;
   logic             r_pulso;
   logic             r_busy;
   logic             r_pend;

   always_ff @(posedge clk_i or negedge reset_i) begin
      if (!reset_i) begin
         r_btn_s1 <= 3'b000;
         r_btn_s2 <= 3'b000;
         r_btn_s3 <= 3'b000;
      end else begin
         r_btn_s1 <= {bus.btn_exit_i, bus.btn_next_i, bus.btn_program_i};
         r_btn_s2 <= r_btn_s1;
         r_btn_s3 <= r_btn_s2;
      end
   end

   // One-clock event per rising edge of the synchronized level.
   assign w_btn_ev  = r_btn_s2 & ~r_btn_s3;
   assign w_ev_prog = w_btn_ev[0];
   assign w_ev_next = w_btn_ev[1];
   assign w_ev_exit = w_btn_ev[2];

   always_ff @(posedge clk_i or negedge reset_i) begin
      if (!reset_i) begin
         r_state   <= S_INIT;
         r_cnt     <= '0;
         r_enables <= EN_INIT;
         r_cambio  <= 4'd1;
         r_graba   <= 1'b0;
         r_pulso   <= 1'b0;
         r_busy    <= 1'b1;
         r_pend    <= 1'b0;
      end else begin
         unique case (r_state)
            S_INIT: begin
               if (r_cnt == INIT_LAST) begin
                  r_state   <= S_READ;
                  r_cnt     <= '0;
                  r_enables <= EN_READ;
                  r_graba   <= 1'b0;
                  r_pulso   <= 1'b0;
                  r_busy    <= 1'b1;
               end else begin
                  r_cnt <= r_cnt + CNT_ONE;
               end
            end

            S_IDLE: begin
               // A queued or fresh program request wins over the periodic read.
               if (w_ev_prog || r_pend) begin
                  r_state   <= S_EDIT;
                  r_cnt     <= '0;
                  r_pend    <= 1'b0;
                  r_enables <= EN_WRITE;
                  r_graba   <= 1'b0;
                  r_pulso   <= 1'b1;
                  r_busy    <= 1'b0;
               end else if (r_cnt == PERIOD_LAST) begin
                  r_state   <= S_READ;
                  r_cnt     <= '0;
                  r_enables <= EN_READ;
                  r_graba   <= 1'b0;
                  r_pulso   <= 1'b0;
                  r_busy    <= 1'b1;
               end else begin
                  r_cnt <= r_cnt + CNT_ONE;
               end
            end

            S_READ: begin
               if (w_ev_prog) begin
                  r_pend <= 1'b1;
               end
               if (r_cnt == READ_LAST) begin
                  r_state   <= S_IDLE;
                  r_cnt     <= '0;
                  r_enables <= EN_IDLE;
                  r_graba   <= 1'b0;
                  r_pulso   <= 1'b0;
                  r_busy    <= 1'b0;
               end else begin
                  r_cnt <= r_cnt + CNT_ONE;
               end
            end

            S_EDIT: begin
               if (w_ev_prog) begin
                  r_state   <= S_COMMIT;
                  r_cnt     <= '0;
                  r_enables <= EN_WRITE;
                  r_graba   <= 1'b1;
                  r_pulso   <= 1'b1;
                  r_busy    <= 1'b1;
               end else if (w_ev_exit) begin
                  r_state   <= S_IDLE;
                  r_cnt     <= '0;
                  r_enables <= EN_IDLE;
                  r_graba   <= 1'b0;
                  r_pulso   <= 1'b0;
                  r_busy    <= 1'b0;
               end else if (w_ev_next) begin
                  r_cambio <= (r_cambio == 4'd9) ? 4'd1 : r_cambio + 4'd1;
               end
            end

            S_COMMIT: begin
               if (r_cnt == WRITE_LAST) begin
                  r_state   <= S_READ;
                  r_cnt     <= '0;
                  r_enables <= EN_READ;
                  r_graba   <= 1'b0;
                  r_pulso   <= 1'b0;
                  r_busy    <= 1'b1;
               end else begin
                  r_cnt <= r_cnt + CNT_ONE;
               end
            end

            default: begin
               r_state   <= S_INIT;
               r_cnt     <= '0;
               r_enables <= EN_INIT;
               r_graba   <= 1'b0;
               r_pulso   <= 1'b0;
               r_busy    <= 1'b1;
               r_pend    <= 1'b0;
            end
         endcase
      end
   end

   assign bus.enables_o       = r_enables;
   assign bus.cambio_o        = r_cambio;
   assign bus.graba_o         = r_graba;
   assign bus.pulsoprogramo_o = r_pulso;
   assign bus.busy_o          = r_busy;

endmodule

// File: tb/tb_rtc_mode_sequencer.sv
// Bench for rtc_mode_sequencer: directed scenarios plus randomized buttons, checked every
// cycle against a mode/duration model and pinned by hand-computed literals.
module tb_rtc_mode_sequencer;

   localparam int INIT_C  = 8;
   localparam int PERIOD  = 20;
   localparam int READ_C  = 6;
   localparam int WRITE_C = 4;

   localparam int M_INIT   = 0;
   localparam int M_IDLE   = 1;
   localparam int M_READ   = 2;
   localparam int M_EDIT   = 3;
   localparam int M_COMMIT = 4;

   logic clk = 1'b0;
   logic rst_n = 1'b1;

   rtc_mode_sequencer_if bus ();

   rtc_mode_sequencer #(
      .INIT_CYCLES  (INIT_C),
      .READ_PERIOD  (PERIOD),
      .READ_CYCLES  (READ_C),
      .WRITE_CYCLES (WRITE_C),
      .CNT_W        (21)
   ) dut (
      .clk_i   (clk),
      .reset_i (rst_n),
      .bus     (bus)
   );

   initial forever #5 clk = ~clk;

   int errors = 0;
   int checks = 0;

   // Model state: mode, cycle index of the last state entry, field, pending request.
   int         m_mode;
   int         m_cyc = 0;
   int         m_ent;
   logic [3:0] m_field;
   bit         m_pend;
   bit [2:0]   h1, h2, h3;  // sampled button levels 1, 2, 3 edges ago {exit,next,prog}

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
      end
   endtask

   task automatic model_reset();
      m_mode  = M_INIT;
      m_ent   = m_cyc;
      m_field = 4'd1;
      m_pend  = 1'b0;
      h1 = 3'b000; h2 = 3'b000; h3 = 3'b000;
   endtask

   task automatic enter(input int mode);
      m_mode = mode;
      m_ent  = m_cyc;
   endtask

   // Called just after a clocking edge with the levels the DUT sampled at that edge.
   task automatic model_edge(input bit [2:0] lv);
      bit [2:0] ev;
      int       age;
      ev  = h2 & ~h3;  // input rising edge seen two edges ago reaches the state now
      h3  = h2; h2 = h1; h1 = lv;
      m_cyc++;
      age = m_cyc - m_ent;
      case (m_mode)
         M_INIT:   if (age == INIT_C) enter(M_READ);
         M_IDLE: begin
            if (ev[0] || m_pend) begin
               m_pend = 1'b0;
               enter(M_EDIT);
            end else if (age == PERIOD) begin
               enter(M_READ);
            end
         end
         M_READ: begin
            if (ev[0]) m_pend = 1'b1;
            if (age == READ_C) enter(M_IDLE);
         end
         M_EDIT: begin
            if (ev[0]) enter(M_COMMIT);
            else if (ev[2]) enter(M_IDLE);
            else if (ev[1]) m_field = (m_field == 4'd9) ? 4'd1 : m_field + 4'd1;
         end
         M_COMMIT: if (age == WRITE_C) enter(M_READ);
         default:  enter(M_INIT);
      endcase
   endtask

   task automatic compare_model();
      logic [2:0] e_en;
      logic       e_g, e_p, e_b;
      case (m_mode)
         M_INIT:   e_en = 3'b100;
         M_READ:   e_en = 3'b010;
         M_EDIT:   e_en = 3'b001;
         M_COMMIT: e_en = 3'b001;
         default:  e_en = 3'b000;
      endcase
      e_g = (m_mode == M_COMMIT);
      e_p = (m_mode == M_EDIT) || (m_mode == M_COMMIT);
      e_b = (m_mode == M_INIT) || (m_mode == M_READ) || (m_mode == M_COMMIT);
      checks++;
      if (bus.enables_o !== e_en || bus.cambio_o !== m_field || bus.graba_o !== e_g ||
          bus.pulsoprogramo_o !== e_p || bus.busy_o !== e_b) begin
         errors++;
         $display("FAIL outputs cyc=%0d: got en=%b cambio=%0d graba=%b prog=%b busy=%b, expected en=%b cambio=%0d graba=%b prog=%b busy=%b",
                  m_cyc, bus.enables_o, bus.cambio_o, bus.graba_o, bus.pulsoprogramo_o,
                  bus.busy_o, e_en, m_field, e_g, e_p, e_b);
      end
   endtask

   // Drive levels at the falling edge, clock once, then compare at the next falling edge.
   task automatic step(input bit p, input bit n, input bit x);
      bus.btn_program_i = p;
      bus.btn_next_i    = n;
      bus.btn_exit_i    = x;
      @(posedge clk);
      if (rst_n) model_edge({x, n, p});
      @(negedge clk);
      compare_model();
   endtask

   task automatic idle_steps(input int k);
      for (int i = 0; i < k; i++) step(1'b0, 1'b0, 1'b0);
   endtask

   task automatic pulse_reset();
      rst_n = 1'b0;
      #1;
      chk("rst_graba_drop", {31'd0, bus.graba_o}, 32'd0);
      chk("rst_en_init", {29'd0, bus.enables_o}, 32'd4);
      chk("rst_busy", {31'd0, bus.busy_o}, 32'd1);
      chk("rst_cambio", {28'd0, bus.cambio_o}, 32'd1);
      model_reset();
      @(posedge clk);
      @(negedge clk);
      rst_n = 1'b1;
      compare_model();
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1, "watchdog");
   end

   initial begin
      int  cnt_a, cnt_b, gseen;
      bit  found;
      bit  lp, ln, lx;
      bus.btn_program_i = 1'b0;
      bus.btn_next_i    = 1'b0;
      bus.btn_exit_i    = 1'b0;
      #1 rst_n = 1'b0;
      model_reset();
      @(negedge clk);
      @(negedge clk);
      chk("reset_en", {29'd0, bus.enables_o}, 32'd4);
      chk("reset_cambio", {28'd0, bus.cambio_o}, 32'd1);
      chk("reset_graba", {31'd0, bus.graba_o}, 32'd0);
      chk("reset_prog", {31'd0, bus.pulsoprogramo_o}, 32'd0);
      chk("reset_busy", {31'd0, bus.busy_o}, 32'd1);
      rst_n = 1'b1;
      compare_model();

      // 1: init 8, read 6, idle 20, read again.
      idle_steps(7);  chk("init_hold", {29'd0, bus.enables_o}, 32'd4);
      idle_steps(1);  chk("first_read", {29'd0, bus.enables_o}, 32'd2);
      idle_steps(5);  chk("read_last", {29'd0, bus.enables_o}, 32'd2);
      idle_steps(1);  chk("idle_entry", {29'd0, bus.enables_o}, 32'd0);
      idle_steps(19); chk("idle_last", {29'd0, bus.enables_o}, 32'd0);
      idle_steps(1);  chk("periodic_read", {29'd0, bus.enables_o}, 32'd2);
      idle_steps(6);  chk("back_idle", {29'd0, bus.enables_o}, 32'd0);

      // 2: edit from idle, three nexts, commit.
      step(1'b1, 1'b0, 1'b0);
      idle_steps(1);  chk("edit_not_yet", {29'd0, bus.enables_o}, 32'd0);
      idle_steps(1);  chk("edit_entry", {29'd0, bus.enables_o}, 32'd1);
      chk("edit_prog", {31'd0, bus.pulsoprogramo_o}, 32'd1);
      for (int i = 0; i < 3; i++) begin
         step(1'b0, 1'b1, 1'b0);
         step(1'b0, 1'b0, 1'b0);
      end
      idle_steps(3);  chk("cambio_4", {28'd0, bus.cambio_o}, 32'd4);
      step(1'b1, 1'b0, 1'b0);
      cnt_a = 0; cnt_b = 0;
      for (int i = 0; i < 16; i++) begin
         step(1'b0, 1'b0, 1'b0);
         if (bus.graba_o === 1'b1) cnt_a++;
         if (bus.enables_o === 3'b010) cnt_b++;
      end
      chk("graba_len", cnt_a, 32'd4);
      chk("readback_len", cnt_b, 32'd6);
      chk("prog_dropped", {31'd0, bus.pulsoprogramo_o}, 32'd0);

      // 3: wrap after nine nexts, held level yields a single step.
      step(1'b1, 1'b0, 1'b0);
      idle_steps(3);  chk("edit_again", {29'd0, bus.enables_o}, 32'd1);
      for (int i = 0; i < 9; i++) begin
         step(1'b0, 1'b1, 1'b0);
         step(1'b0, 1'b0, 1'b0);
      end
      idle_steps(3);  chk("wrap_9", {28'd0, bus.cambio_o}, 32'd4);
      for (int i = 0; i < 50; i++) step(1'b0, 1'b1, 1'b0);
      idle_steps(3);  chk("hold_once", {28'd0, bus.cambio_o}, 32'd5);
      step(1'b0, 1'b0, 1'b1);
      idle_steps(3);  chk("exit_idle", {29'd0, bus.enables_o}, 32'd0);

      // 4: program during read is queued until the pass completes.
      found = 1'b0;
      for (int i = 0; i < 100 && !found; i++) begin
         step(1'b0, 1'b0, 1'b0);
         if (bus.enables_o === 3'b010) found = 1'b1;
      end
      chk("wait_read", {31'd0, found}, 32'd1);
      step(1'b1, 1'b0, 1'b0);
      cnt_a = (bus.enables_o === 3'b010) ? 1 : 0;
      cnt_b = 0; found = 1'b0;
      for (int i = 0; i < 40 && !found; i++) begin
         step(1'b0, 1'b0, 1'b0);
         if (bus.enables_o === 3'b010) cnt_a++;
         if (bus.enables_o === 3'b000) cnt_b++;
         if (bus.enables_o === 3'b001) found = 1'b1;
      end
      chk("pending_edit", {31'd0, found}, 32'd1);
      chk("pending_read_rest", cnt_a, 32'd5);
      chk("pending_idle", cnt_b, 32'd1);
      gseen = 0;
      step(1'b0, 1'b0, 1'b1);
      for (int i = 0; i < 3; i++) begin
         step(1'b0, 1'b0, 1'b0);
         if (bus.graba_o === 1'b1) gseen++;
      end
      chk("exit_no_write", gseen, 32'd0);
      chk("exit_en", {29'd0, bus.enables_o}, 32'd0);
      chk("exit_cambio", {28'd0, bus.cambio_o}, 32'd5);

      // 5: program beats next; program during commit is ignored.
      step(1'b1, 1'b0, 1'b0);
      idle_steps(3);
      step(1'b1, 1'b1, 1'b0);
      idle_steps(2);
      chk("prio_commit", {31'd0, bus.graba_o}, 32'd1);
      chk("prio_cambio", {28'd0, bus.cambio_o}, 32'd5);
      step(1'b1, 1'b0, 1'b0);
      idle_steps(3);  chk("commit_to_read", {29'd0, bus.enables_o}, 32'd2);
      idle_steps(6);  chk("no_reedit", {29'd0, bus.enables_o}, 32'd0);

      // 6: reset with the commit counter at 2.
      step(1'b1, 1'b0, 1'b0);
      idle_steps(3);
      step(1'b1, 1'b0, 1'b0);
      idle_steps(4);
      chk("pre_reset_commit", {31'd0, bus.graba_o}, 32'd1);
      pulse_reset();
      idle_steps(7);  chk("reinit_hold", {29'd0, bus.enables_o}, 32'd4);
      idle_steps(1);  chk("reinit_read", {29'd0, bus.enables_o}, 32'd2);

      // Randomized button levels with rare resets.
      lp = 1'b0; ln = 1'b0; lx = 1'b0;
      for (int i = 0; i < 3000; i++) begin
         if ($urandom_range(0, 11) == 0) lp = ~lp;
         if ($urandom_range(0, 5) == 0)  ln = ~ln;
         if ($urandom_range(0, 19) == 0) lx = ~lx;
         if ($urandom_range(0, 999) == 0) pulse_reset();
         else step(lp, ln, lx);
      end

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
